// File: rtl/dct_pkg.sv
// Shared types and elaboration-time helpers for the DCT coefficient MAC.
// cos_q builds the 1D cosine ROM contents with integer-only math, so the
// table is a pure constant and needs no real-number support in the tools.
package dct_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_e;

  // Default block size and the matching pixel index width (n1,n2 packed).
  localparam int DCT_N = 8;
  localparam int IDX_W = 2 * $clog2(DCT_N);

  // Q30 fixed point used only while building the ROM.
  localparam longint Q_ONE  = 64'sd1 <<< 30;
  localparam longint Q60    = 64'sd1 <<< 60;
  localparam longint PI_Q30 = 64'sd3373259426;

  // Integer square root (floor), digit-by-digit.
  function automatic longint isqrt(input longint v);
    longint rem;
    longint res;
    longint b;
    rem = v;
    res = 0;
    b   = 64'sd1 <<< 62;
    while (b > rem) b = b >>> 2;
    while (b != 0) begin
      if (rem >= res + b) begin
        rem = rem - (res + b);
        res = (res >>> 1) + b;
      end else begin
        res = res >>> 1;
      end
      b = b >>> 2;
    end
    return res;
  endfunction

  // c(k,n) = round(a(k) * cos((2n+1)k*pi/(2N)) * 2^cfrac), ties away from zero.
  function automatic int cos_q(input int k, input int n, input int nn, input int cfrac);
    longint m;
    longint x;
    longint x2;
    longint term;
    longint csum;
    longint amp;
    longint p;
    longint mag;
    longint r;
    int     sgn;
    // Angle in units of pi/(2N); one full turn is 4N units.
    m   = longint'((2 * n + 1) * k) % longint'(4 * nn);
    sgn = 1;
    if (m > 2 * nn) m = 4 * nn - m;
    if (m > nn) begin
      m   = 2 * nn - m;
      sgn = -1;
    end
    // Reduced angle lies in [0, pi/2]; Taylor series converges quickly there.
    x    = (m * PI_Q30) / longint'(2 * nn);
    x2   = (x * x) >>> 30;
    term = Q_ONE;
    csum = Q_ONE;
    for (int i = 1; i <= 12; i++) begin
      term = -((term * x2) >>> 30) / longint'((2 * i - 1) * (2 * i));
      csum = csum + term;
    end
    amp = isqrt(((k == 0) ? 64'sd1 : 64'sd2) * (Q60 / longint'(nn)));
    p   = amp * csum;
    if (p < 0) begin
      mag = -p;
      sgn = -sgn;
    end else begin
      mag = p;
    end
    r = (mag + (64'sd1 <<< (59 - cfrac))) >>> (60 - cfrac);
    return int'(longint'(sgn) * r);
  endfunction

endpackage

// File: rtl/dct_coeff_mac_if.sv
// Pixel-in / coefficient-out streaming handshakes of one coefficient engine.
interface dct_coeff_mac_if #(
  parameter int PIX_W = 8,
  parameter int ACC_W = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [PIX_W-1:0] in_pixel;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_coeff;

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_coeff
  );

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_coeff
  );
endinterface

// File: rtl/dct_cos_rom.sv
// Combinational N x N table of 1D DCT-II cosine terms c(k,n) in Q(C_FRAC).
module dct_cos_rom
  import dct_pkg::*;
#(
  parameter int N      = 8,
  parameter int C_FRAC = 10
) (
  input  logic [$clog2(N)-1:0] k_i,
  input  logic [$clog2(N)-1:0] n_i,
  output logic signed [C_FRAC+1:0] c_o
);

  localparam int CW = C_FRAC + 2;

  logic signed [CW-1:0] tbl [N*N];

  for (genvar i = 0; i < N * N; i++) begin : g_tbl
    localparam int V = cos_q(i / N, i % N, N, C_FRAC);
    assign tbl[i] = CW'(V);
  end

  assign c_o = tbl[{k_i, n_i}];

endmodule

// File: rtl/dct_coeff_mac.sv
// Streams one N x N block and accumulates a single 2D DCT-II coefficient
// F(k1,k2). Three-stage datapath: operand capture, multiply, saturating add.
module dct_coeff_mac
  import dct_pkg::*;
#(
  parameter int N      = 8,
  parameter int PIX_W  = 8,
  parameter int C_FRAC = 10,
  parameter int ACC_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [$clog2(N)-1:0] k1,
  input  logic [$clog2(N)-1:0] k2,
  output logic                 busy,
  output logic                 ovf,
  dct_coeff_mac_if.slave       bus
);

  localparam int LG = $clog2(N);
  localparam int IW = 2 * LG;
  localparam int CW = C_FRAC + 2;
  localparam int PW = PIX_W + CW;
  localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;

  localparam logic [IW-1:0]          IDX_LAST = IW'(N * N - 1);
  localparam logic signed [2*CW-1:0] T_HALF   = (2 * CW)'(1 <<< (C_FRAC - 1));
  localparam logic signed [SW-1:0]   ACC_MAX  = {{(SW - ACC_W + 1){1'b0}}, {(ACC_W - 1){1'b1}}};
  localparam logic signed [SW-1:0]   ACC_MIN  = {{(SW - ACC_W + 1){1'b1}}, {(ACC_W - 1){1'b0}}};

  // 2D term: round the Q(2*C_FRAC) product back to Q(C_FRAC), floor-shift after +half.
  function automatic logic signed [CW-1:0] round_t(input logic signed [2*CW-1:0] p);
    logic signed [2*CW-1:0] s;
    s = (p + T_HALF) >>> C_FRAC;
    return CW'(s);
  endfunction

  function automatic logic sat_hit(input logic signed [SW-1:0] s);
    return (s > ACC_MAX) || (s < ACC_MIN);
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_val(input logic signed [SW-1:0] s);
    if (s > ACC_MAX) return ACC_W'(ACC_MAX);
    if (s < ACC_MIN) return ACC_W'(ACC_MIN);
    return ACC_W'(s);
  endfunction

  state_e                   state_q;
  logic [LG-1:0]            k1_q, k2_q;
  logic [IW-1:0]            idx_q;
  logic                     drain_q;
  logic                     busy_q, in_ready_q, out_valid_q;
  logic                     accept, start_fire;
  logic signed [CW-1:0]     c1, c2, t_d;
  logic signed [PIX_W-1:0]  pix_p0;
  logic signed [CW-1:0]     t_p0;
  logic                     vld_p0, vld_p1;
  logic signed [PW-1:0]     prod_p1;
  logic signed [SW-1:0]     sum_d;
  logic signed [ACC_W-1:0]  acc_d, acc_q;
  logic                     ovf_q;

  assign accept     = bus.in_valid & in_ready_q;
  assign start_fire = (state_q == IDLE) && start;

  dct_cos_rom #(.N(N), .C_FRAC(C_FRAC)) u_rom_v (
    .k_i (k1_q),
    .n_i (idx_q[IW-1:LG]),
    .c_o (c1)
  );

  dct_cos_rom #(.N(N), .C_FRAC(C_FRAC)) u_rom_h (
    .k_i (k2_q),
    .n_i (idx_q[LG-1:0]),
    .c_o (c2)
  );

  assign t_d = round_t((2 * CW)'(c1) * (2 * CW)'(c2));

  // Control FSM: frequency latch, pixel index, drain timer and registered handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      k1_q        <= '0;
      k2_q        <= '0;
      idx_q       <= '0;
      drain_q     <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            k1_q       <= k1;
            k2_q       <= k2;
            idx_q      <= '0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            idx_q <= idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              in_ready_q <= 1'b0;
              drain_q    <= 1'b0;
              state_q    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Two cycles let the last pixel pass the multiply and add stages.
          drain_q <= 1'b1;
          if (drain_q) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Valid bits through the datapath; bubbles stay zero so they never accumulate.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= accept;
      vld_p1 <= vld_p0;
    end
  end

  // Stage p0: capture accepted pixel and its 2D cosine term.
  always_ff @(posedge clk) begin
    if (accept) begin
      pix_p0 <= bus.in_pixel;
      t_p0   <= t_d;
    end
  end

  // Stage p1: pixel * 2D term.
  always_ff @(posedge clk) begin
    if (vld_p0) prod_p1 <= PW'(pix_p0) * PW'(t_p0);
  end

  // Stage p2: widen, add and clamp to the accumulator range.
  assign sum_d = SW'(acc_q) + SW'(prod_p1);
  assign acc_d = sat_val(sum_d);

  // Accumulator and sticky overflow, both cleared by an accepted start.
  always_ff @(posedge clk) begin
    if (reset || start_fire) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (vld_p1) begin
      acc_q <= acc_d;
      if (sat_hit(sum_d)) ovf_q <= 1'b1;
    end
  end

  assign busy          = busy_q;
  assign ovf           = ovf_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_coeff = acc_q;

endmodule
